// File: rtl/knn_core_if.sv
// Host-side streaming port of the KNN accelerator: load/stream qualifiers, selects,
// test/training points and the neighbour-index readout.
interface knn_core_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic              DONE;
  logic [15:0]       SEL;
  logic [15:0]       SOLVER_SEL;
  logic [DATA_W-1:0] DATA_1;
  logic [DATA_W-1:0] DATA_2;
  logic [15:0]       DATA_OUT;

  modport master (
    output valid, DONE, SEL, SOLVER_SEL, DATA_1, DATA_2,
    input  DATA_OUT
  );

  modport slave (
    input  valid, DONE, SEL, SOLVER_SEL, DATA_1, DATA_2,
    output DATA_OUT
  );
endinterface

// File: rtl/knn_core.sv
// K-nearest-neighbour core: N_SOLVERS solvers share one training stream, each keeping
// a sorted list of its HW_K closest samples (distance + sample index).
module knn_core #(
  parameter int HW_K      = 10,
  parameter int N_SOLVERS = 10,
  parameter int DATA_W    = 32
) (
  input logic         clk,
  input logic         rst,
  knn_core_if.slave   host
);
  localparam int HalfW = DATA_W / 2;
  localparam int DistW = DATA_W + 3;

  typedef logic [DistW-1:0] dist_t;

  logic [DATA_W-1:0]         tp_q   [N_SOLVERS];
  logic [DATA_W-1:0]         tp_d   [N_SOLVERS];
  logic [HW_K-1:0][DistW-1:0] dist_q [N_SOLVERS];
  logic [HW_K-1:0][DistW-1:0] dist_d [N_SOLVERS];
  logic [HW_K-1:0][15:0]      idx_q  [N_SOLVERS];
  logic [HW_K-1:0][15:0]      idx_d  [N_SOLVERS];
  logic [15:0]               cnt_q, cnt_d;

  logic                       accept;
  dist_t                      d_cur  [N_SOLVERS];
  logic [HW_K-1:0]            lt     [N_SOLVERS];
  logic [HW_K:0]              lt_sh  [N_SOLVERS];
  logic [HW_K:0][DistW-1:0]   d_sh   [N_SOLVERS];
  logic [HW_K:0][15:0]        i_sh   [N_SOLVERS];
  logic [15:0]                data_out;

  // Squared Euclidean distance; differences carry one extra bit so they never overflow.
  function automatic dist_t dist_f(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic signed [HalfW:0]    dx, dy;
    logic signed [DATA_W+1:0] sqx, sqy;
    dx  = {a[DATA_W-1], a[DATA_W-1:HalfW]} - {b[DATA_W-1], b[DATA_W-1:HalfW]};
    dy  = {a[HalfW-1], a[HalfW-1:0]} - {b[HalfW-1], b[HalfW-1:0]};
    sqx = dx * dx;
    sqy = dy * dy;
    return {1'b0, sqx} + {1'b0, sqy};
  endfunction

  always_comb begin
    accept = host.valid && !host.DONE;
    cnt_d  = accept ? cnt_q + 16'd1 : cnt_q;
    for (int s = 0; s < N_SOLVERS; s++) begin
      tp_d[s] = tp_q[s];
      if (host.DONE && host.valid && host.SOLVER_SEL == 16'(s)) tp_d[s] = host.DATA_1;

      d_cur[s] = dist_f(host.DATA_2, tp_q[s]);
      for (int k = 0; k < HW_K; k++) lt[s][k] = d_cur[s] < dist_q[s][k];
      // lt is a thermometer over the sorted list: the first set bit is the insert slot,
      // later set bits take the entry from the slot above.
      lt_sh[s] = {lt[s], 1'b0};
      d_sh[s]  = {dist_q[s], d_cur[s]};
      i_sh[s]  = {idx_q[s], cnt_q};
      for (int k = 0; k < HW_K; k++) begin
        dist_d[s][k] = dist_q[s][k];
        idx_d[s][k]  = idx_q[s][k];
        if (accept && lt[s][k]) begin
          dist_d[s][k] = lt_sh[s][k] ? d_sh[s][k] : d_cur[s];
          idx_d[s][k]  = lt_sh[s][k] ? i_sh[s][k] : cnt_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      for (int s = 0; s < N_SOLVERS; s++) begin
        tp_q[s]   <= '0;
        dist_q[s] <= '1;
        idx_q[s]  <= '1;
      end
    end else begin
      cnt_q <= cnt_d;
      for (int s = 0; s < N_SOLVERS; s++) begin
        tp_q[s]   <= tp_d[s];
        dist_q[s] <= dist_d[s];
        idx_q[s]  <= idx_d[s];
      end
    end
  end

  always_comb begin
    data_out = 16'hFFFF;
    for (int s = 0; s < N_SOLVERS; s++) begin
      for (int k = 0; k < HW_K; k++) begin
        if (host.SOLVER_SEL == 16'(s) && host.SEL == 16'(k)) data_out = idx_q[s][k];
      end
    end
  end

  assign host.DATA_OUT = data_out;
endmodule

// File: tb/tb_knn_core.sv
// Directed bench for knn_core: reset, ordering, ties, signed coordinates, multi-solver
// readout and asynchronous mid-stream reset.
module tb_knn_core;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  knn_core_if #(.DATA_W(32)) bus ();

  knn_core #(
    .HW_K     (10),
    .N_SOLVERS(10),
    .DATA_W   (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .host(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pt(input int x, input int y);
    return {x[15:0], y[15:0]};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input int s, input int k, input logic [15:0] exp);
    bus.SOLVER_SEL = 16'(s);
    bus.SEL        = 16'(k);
    #1;
    check($sformatf("%s s%0d k%0d", tag, s, k), bus.DATA_OUT, exp);
  endtask

  task automatic sample(input int x, input int y);
    bus.DONE   = 1'b0;
    bus.valid  = 1'b1;
    bus.DATA_2 = pt(x, y);
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
  endtask

  task automatic idle();
    bus.valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int s, input int x, input int y);
    bus.DONE       = 1'b1;
    bus.valid      = 1'b1;
    bus.SOLVER_SEL = 16'(s);
    bus.DATA_1     = pt(x, y);
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    bus.DONE  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst            = 1'b0;
    bus.valid      = 1'b0;
    bus.DONE       = 1'b0;
    bus.SEL        = '0;
    bus.SOLVER_SEL = '0;
    bus.DATA_1     = '0;
    bus.DATA_2     = '0;
    #12;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset: every slot of every solver (and out-of-range selects) reads empty.
    for (int s = 0; s <= 10; s++)
      for (int k = 0; k <= 10; k++) rd("reset", s, k, 16'hFFFF);

    // Ascending distances from origin: slot k holds sample k, samples 10/11 dropped.
    load(0, 0, 0);
    for (int i = 1; i <= 12; i++) sample(0, i);
    for (int k = 0; k < 10; k++) rd("asc", 0, k, 16'(k));
    rd("asc", 3, 4, 16'd4);
    rd("asc_oob_sel", 0, 10, 16'hFFFF);

    // Descending: nearest is the last sample.
    do_reset();
    for (int i = 0; i < 12; i++) sample(0, 12 - i);
    for (int k = 0; k < 10; k++) rd("desc", 0, k, 16'(11 - k));

    // Ties and gaps; DONE=1 with valid must not consume an index.
    do_reset();
    sample(0, 5);
    idle();
    sample(0, 5);
    idle();
    sample(0, 3);
    rd("tie", 0, 0, 16'd2);
    rd("tie", 0, 1, 16'd0);
    rd("tie", 0, 2, 16'd1);
    rd("tie", 0, 3, 16'hFFFF);
    load(15, 0, 0);
    bus.DONE   = 1'b1;
    bus.valid  = 1'b1;
    bus.DATA_2 = pt(0, 0);
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    sample(0, 4);
    rd("gap_idx", 0, 0, 16'd2);
    rd("gap_idx", 0, 1, 16'd3);
    rd("gap_idx", 0, 2, 16'd0);

    // Multi-solver with signed coordinates.
    do_reset();
    load(0, 0, 0);
    load(1, 0, 100);
    load(2, 0, -5);
    load(3, -7, 40);
    for (int i = 0; i < 100; i++) sample(0, i);
    rd("multi", 0, 0, 16'd0);
    rd("multi", 0, 9, 16'd9);
    rd("multi", 1, 0, 16'd99);
    rd("multi", 1, 1, 16'd98);
    rd("multi_neg", 2, 0, 16'd0);
    rd("multi_neg", 2, 1, 16'd1);
    rd("multi_negx", 3, 0, 16'd40);
    rd("multi_negx", 3, 1, 16'd39);
    rd("multi_negx", 3, 2, 16'd41);
    rd("multi_oob_solver", 10, 0, 16'hFFFF);

    // Asynchronous mid-stream reset.
    do_reset();
    for (int i = 1; i <= 5; i++) sample(0, i);
    rd("pre_rst", 0, 0, 16'd0);
    rst = 1'b0;
    #1;
    check("async_rst", bus.DATA_OUT, 16'hFFFF);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 1; i <= 3; i++) sample(0, i);
    for (int k = 0; k < 3; k++) rd("mid_rst", 0, k, 16'(k));
    for (int k = 3; k < 10; k++) rd("mid_rst", 0, k, 16'hFFFF);
    rd("mid_rst", 5, 0, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
